// File: rtl/vreg_pkg.sv
// Shared participation (PPP) encodings and lane-mask helper, used by the
// register file and by the processor's forwarding logic.
package vreg_pkg;

    typedef enum logic [2:0] {
        PPP_ALL   = 3'b000,
        PPP_UPPER = 3'b001,
        PPP_LOWER = 3'b010,
        PPP_EVEN  = 3'b011,
        PPP_ODD   = 3'b100
    } ppp_e;

    localparam int VREG_MAX_W = 1024;

    // Bit 0 is the MSB: bits are shifted in MSB-first, so after w steps
    // big-endian bit i sits at vector index w-1-i. Codes 101-111 select all bits.
    function automatic logic [VREG_MAX_W-1:0] ppp_lane_mask(input logic [2:0] ppp, input int w);
        logic [VREG_MAX_W-1:0] m;
        logic                  sel;
        m = '0;
        for (int i = 0; i < VREG_MAX_W; i++) begin
            if (i < w) begin
                case (ppp)
                    PPP_UPPER: sel = (i < w / 2);
                    PPP_LOWER: sel = (i >= w / 2);
                    PPP_EVEN:  sel = (((i / 8) % 2) == 0);
                    PPP_ODD:   sel = (((i / 8) % 2) == 1);
                    default:   sel = 1'b1;
                endcase
                m = {m[VREG_MAX_W-2:0], sel};
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/vreg_ppp_mask.sv
// Decodes a participation field into a DATA_W-bit write-lane mask.
module vreg_ppp_mask
    import vreg_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]        ppp,
    output logic [DATA_W-1:0] mask
);

    assign mask = DATA_W'(ppp_lane_mask(ppp, DATA_W));

endmodule

// File: rtl/vreg_file_mp.sv
// Multi-read-port register file with partial (PPP) writes and a per-register
// in-flight reservation scoreboard. Define VREG_FILE_BYPASS_EN for write-to-read bypass.
module vreg_file_mp
    import vreg_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32,
    parameter int NRD    = 2
) (
    input  logic                          Clock,
    input  logic                          Reset_n,
    input  logic                          wr_en,
    input  logic [$clog2(NREGS)-1:0]      wr_addr,
    input  logic [2:0]                    wr_ppp,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [NRD-1:0]                rd_en,
    input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
    output logic [NRD*DATA_W-1:0]         rd_data,
    input  logic                          rsv_en,
    input  logic [$clog2(NREGS)-1:0]      rsv_addr,
    input  logic                          flush,
    output logic [NRD-1:0]                rd_busy,
    output logic                          stall
);

    localparam int AW = $clog2(NREGS);

    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;

    vreg_ppp_mask #(.DATA_W(DATA_W)) u_wr_mask (
        .ppp  (wr_ppp),
        .mask (wr_mask)
    );

    // Register 0 is never written, so it holds its reset value of zero.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= (regs[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // Flush beats reserve, reserve beats the completing write.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
            if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) busy <= '0;
        else          busy <= busy_nxt;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] data;
        logic              bsy;

        // Port 0 occupies the most significant field of the packed buses.
        assign ra     = rd_addr[(NRD-1-p)*AW +: AW];
        assign stored = regs[ra];

`ifdef VREG_FILE_BYPASS_EN
        logic hit;
        assign hit  = wr_en && (wr_addr == ra) && (ra != '0);
        assign data = hit ? ((stored & ~wr_mask) | (wr_data & wr_mask)) : stored;
        assign bsy  = hit ? 1'b0 : busy[ra];
`else
        assign data = stored;
        assign bsy  = busy[ra];
`endif

        // Gate with reset so a bypassed write cannot leak out while in reset.
        assign rd_data[(NRD-1-p)*DATA_W +: DATA_W] = Reset_n ? data : '0;
        assign rd_busy[p] = Reset_n & bsy;
    end

    assign stall = |(rd_en & rd_busy);

endmodule

// File: tb/tb_vreg_file_mp.sv
// Self-checking bench for vreg_file_mp: directed vector table, bypass and
// async-reset sequences, then random traffic against a behavioural model.
module tb_vreg_file_mp;

    localparam int DW = 64;

    logic          Clock;
    logic          Reset_n;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [2:0]    wr_ppp;
    logic [DW-1:0] wr_data;
    logic [1:0]    rd_en;
    logic [9:0]    rd_addr;
    logic [127:0]  rd_data;
    logic          rsv_en;
    logic [4:0]    rsv_addr;
    logic          flush;
    logic [1:0]    rd_busy;
    logic          stall;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] m_regs [32];
    logic [31:0]   m_busy;

    vreg_file_mp #(.DATA_W(64), .NREGS(32), .NRD(2)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_ppp   (wr_ppp),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .rd_busy  (rd_busy),
        .stall    (stall)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic          we;
        logic [4:0]    wa;
        logic [2:0]    ppp;
        logic [DW-1:0] wd;
        logic          re;
        logic [4:0]    rsa;
        logic          fl;
        logic [1:0]    ren;
        logic [4:0]    ra0;
        logic [4:0]    ra1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [1:0]    ebusy;
        logic          estall;
    } vec_t;

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [2:0] ppp, logic [DW-1:0] wd,
                                logic re, logic [4:0] rsa, logic fl, logic [1:0] ren,
                                logic [4:0] ra0, logic [4:0] ra1, logic [DW-1:0] e0,
                                logic [DW-1:0] e1, logic [1:0] ebusy, logic estall);
        vec_t v;
        v.we = we; v.wa = wa; v.ppp = ppp; v.wd = wd; v.re = re; v.rsa = rsa; v.fl = fl;
        v.ren = ren; v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
        v.ebusy = ebusy; v.estall = estall;
        return v;
    endfunction

    // Byte-granular lane mask built straight from the PPP table; byte 0 is the MSB byte.
    function automatic logic [DW-1:0] spec_mask(logic [2:0] ppp);
        logic [DW-1:0] m;
        logic [DW-1:0] ff;
        bit inc;
        m  = '0;
        ff = 64'hFF;
        for (int b = 0; b < DW / 8; b++) begin
            case (ppp)
                3'd1:    inc = (b < DW / 16);
                3'd2:    inc = (b >= DW / 16);
                3'd3:    inc = (b % 2 == 0);
                3'd4:    inc = (b % 2 == 1);
                default: inc = 1'b1;
            endcase
            if (inc) m = m | (ff << (8 * (DW / 8 - 1 - b)));
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] m_data(logic [4:0] a);
        logic [DW-1:0] v;
        v = m_regs[a];
`ifdef VREG_FILE_BYPASS_EN
        if (wr_en && wr_addr == a && a != 0)
            v = (v & ~spec_mask(wr_ppp)) | (wr_data & spec_mask(wr_ppp));
`endif
        return v;
    endfunction

    function automatic logic m_bsy(logic [4:0] a);
`ifdef VREG_FILE_BYPASS_EN
        if (wr_en && wr_addr == a && a != 0) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_busy = '0;
    endtask

    task automatic model_edge();
        if (wr_en && wr_addr != 0)
            m_regs[wr_addr] = (m_regs[wr_addr] & ~spec_mask(wr_ppp)) | (wr_data & spec_mask(wr_ppp));
        if (flush) begin
            m_busy = '0;
        end else begin
            if (wr_en)  m_busy[wr_addr]  = 1'b0;
            if (rsv_en) m_busy[rsv_addr] = 1'b1;
        end
        m_busy[0] = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_ppp = 0; wr_data = 0;
        rsv_en = 0; rsv_addr = 0; flush = 0; rd_en = 0; rd_addr = 0;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_model(input string tag);
        logic [4:0] a0, a1;
        logic [1:0] eb;
        a0 = rd_addr[9:5];
        a1 = rd_addr[4:0];
        eb = {m_bsy(a1), m_bsy(a0)};
        chk({tag, "_d0"}, rd_data[127:64], m_data(a0));
        chk({tag, "_d1"}, rd_data[63:0], m_data(a1));
        chk({tag, "_busy"}, 64'(rd_busy), 64'(eb));
        chk({tag, "_stall"}, 64'(stall), 64'(|(rd_en & eb)));
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = mk(1, 5, 0, 64'h0123456789ABCDEF, 0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0);
        tbl[1]  = mk(1, 5, 3, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 2'b00, 0, 2, 0, 0, 2'b00, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 5, 5, 64'hFF23FF67FFABFFEF, 64'hFF23FF67FFABFFEF, 2'b00, 0);
        tbl[3]  = mk(1, 0, 0, 64'hDEADBEEFDEADBEEF, 1, 0, 0, 2'b00, 6, 7, 0, 0, 2'b00, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 7, 0, 2'b00, 1, 2, 0, 0, 2'b00, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 7, 0, 0, 2'b10, 1);
        tbl[7]  = mk(1, 7, 0, 64'h1111111111111111, 0, 0, 0, 2'b00, 1, 2, 0, 0, 2'b00, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 7, 0, 64'h1111111111111111, 2'b00, 0);
        tbl[9]  = mk(1, 9, 0, 64'h2222222222222222, 1, 9, 0, 2'b00, 1, 2, 0, 0, 2'b00, 0);
        tbl[10] = mk(0, 0, 0, 0, 1, 9, 1, 2'b01, 9, 1, 64'h2222222222222222, 0, 2'b01, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 9, 1, 64'h2222222222222222, 0, 2'b00, 0);

        // Reset state, with a write pending that must not bypass out.
        model_reset();
        idle();
        Reset_n = 0;
        wr_en = 1; wr_addr = 5; wr_data = '1; rd_en = 2'b11; rd_addr = {5'd5, 5'd3};
        #2;
        chk("rst_d0", rd_data[127:64], 0);
        chk("rst_d1", rd_data[63:0], 0);
        chk("rst_busy", 64'(rd_busy), 0);
        chk("rst_stall", 64'(stall), 0);
        #10;
        Reset_n = 1;
        idle();
        tick();

        for (int i = 0; i < 12; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_ppp = tbl[i].ppp; wr_data = tbl[i].wd;
            rsv_en = tbl[i].re; rsv_addr = tbl[i].rsa; flush = tbl[i].fl;
            rd_en = tbl[i].ren; rd_addr = {tbl[i].ra0, tbl[i].ra1};
            #1;
            chk($sformatf("vec%0d_d0", i), rd_data[127:64], tbl[i].e0);
            chk($sformatf("vec%0d_d1", i), rd_data[63:0], tbl[i].e1);
            chk($sformatf("vec%0d_busy", i), 64'(rd_busy), 64'(tbl[i].ebusy));
            chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(tbl[i].estall));
            tick();
        end

        // Write-to-read in the same cycle on a reserved register.
        idle();
        wr_en = 1; wr_addr = 3; wr_ppp = 0; wr_data = 64'hAAAAAAAAAAAAAAAA;
        rsv_en = 1; rsv_addr = 3;
        tick();
        idle();
        wr_en = 1; wr_addr = 3; wr_ppp = 1; wr_data = 64'h5555555555555555;
        rd_en = 2'b01; rd_addr = {5'd3, 5'd0};
        #1;
`ifdef VREG_FILE_BYPASS_EN
        chk("byp_same_d", rd_data[127:64], 64'h55555555AAAAAAAA);
        chk("byp_same_busy", 64'(rd_busy[0]), 0);
        chk("byp_same_stall", 64'(stall), 0);
`else
        chk("byp_same_d", rd_data[127:64], 64'hAAAAAAAAAAAAAAAA);
        chk("byp_same_busy", 64'(rd_busy[0]), 1);
        chk("byp_same_stall", 64'(stall), 1);
`endif
        tick();
        wr_en = 0;
        #1;
        chk("byp_next_d", rd_data[127:64], 64'h55555555AAAAAAAA);
        chk("byp_next_busy", 64'(rd_busy[0]), 0);

        // Asynchronous reset between edges, with a write in flight.
        idle();
        rsv_en = 1; rsv_addr = 5;
        tick();
        idle();
        wr_en = 1; wr_addr = 5; wr_ppp = 0; wr_data = 64'h0F0F0F0F0F0F0F0F;
        rd_en = 2'b11; rd_addr = {5'd5, 5'd3};
        #1;
        check_model("pre_arst");
        #2;
        Reset_n = 0;
        #1;
        chk("arst_d0", rd_data[127:64], 0);
        chk("arst_d1", rd_data[63:0], 0);
        chk("arst_busy", 64'(rd_busy), 0);
        chk("arst_stall", 64'(stall), 0);
        @(posedge Clock);
        #2;
        Reset_n = 1;
        model_reset();
        wr_en = 0;
        #1;
        chk("arst_discard_d0", rd_data[127:64], 0);
        check_model("post_arst");
        tick();

        // Random traffic against the model; small address range forces collisions.
        for (int c = 0; c < 400; c++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = 5'($urandom_range(0, 7));
            wr_ppp   = 3'($urandom_range(0, 7));
            wr_data  = {$urandom, $urandom};
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 9) == 0);
            rd_en    = 2'($urandom_range(0, 3));
            rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
